// File: rtl/gb_cart_pkg.sv
// rtl/gb_cart_pkg.sv - shared types and helpers for the cartridge RAM store
package gb_cart_pkg;

    typedef enum logic [2:0] {
        BK_IDLE,
        BK_SAVE_RD,
        BK_SAVE_XFER,
        BK_LOAD,
        BK_DONE
    } bk_state_t;

    localparam logic [7:0] MBC2_TYPE      = 8'h05;
    localparam logic [7:0] MBC2_BATT_TYPE = 8'h06;

    // Save image length in bytes from header bytes 0x147 / 0x149; 0 means no RAM.
    function automatic logic [17:0] cram_len(input logic [7:0] mbc_type,
                                             input logic [7:0] ram_size);
        logic [17:0] len;
        if (mbc_type == MBC2_TYPE || mbc_type == MBC2_BATT_TYPE) begin
            len = 18'd512;
        end else begin
            case (ram_size)
                8'd1:    len = 18'd2048;
                8'd2:    len = 18'd8192;
                8'd3:    len = 18'd32768;
                8'd4:    len = 18'd131072;
                8'd5:    len = 18'd65536;
                default: len = 18'd0;
            endcase
        end
        return len;
    endfunction

endpackage

// File: rtl/cart_dpram.sv
// rtl/cart_dpram.sv - true dual-port byte RAM, registered outputs, old-data read-during-write
module cart_dpram #(
    parameter int ADDR_W = 17
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_we,
    input  logic [7:0]        a_di,
    output logic [7:0]        a_do,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_we,
    input  logic [7:0]        b_di,
    output logic [7:0]        b_do
);

    logic [7:0] mem [0:(2**ADDR_W)-1];

    // Port A is written last so a same-address collision keeps the CPU byte.
    always_ff @(posedge clk_sys) begin
        if (b_we) mem[b_addr] <= b_di;
        if (a_we) mem[a_addr] <= a_di;
        if (reset) begin
            a_do <= 8'h00;
            b_do <= 8'h00;
        end else begin
            a_do <= mem[a_addr];
            b_do <= mem[b_addr];
        end
    end

endmodule

// File: rtl/cart_ram_store.sv
// rtl/cart_ram_store.sv - cart RAM backing store with battery save/load streaming engine
module cart_ram_store
    import gb_cart_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic              ram_rd,
    input  logic              ram_wr,
    input  logic [7:0]        ram_di,
    output logic [7:0]        ram_do,
    input  logic [7:0]        cart_mbc_type,
    input  logic [7:0]        cart_ram_size,
    input  logic              bk_load,
    input  logic              bk_save,
    output logic              bk_busy,
    output logic              bk_done,
    output logic              bk_dirty,
    output logic [7:0]        sv_out_data,
    output logic              sv_out_valid,
    input  logic              sv_out_ready,
    input  logic [7:0]        sv_in_data,
    input  logic              sv_in_valid,
    output logic              sv_in_ready
);

    localparam logic [ADDR_W:0] LEN_ONE = 1;

    bk_state_t         state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] b_addr;
    logic              b_we;
    logic [7:0]        b_do;
    logic              last;
    logic              start_any;
    logic              start_save;
    logic              dirty_set;
    logic              dirty_clr;
    logic              unused_ok;

    // Reads ignore the strobe: the data register follows the address every cycle.
    assign unused_ok = ram_rd;

    assign len = cram_len(cart_mbc_type, cart_ram_size);

    // Port B prefetches the next save byte so SAVE_RD can latch it immediately.
    always_comb begin
        b_addr     = idx;
        last       = ({1'b0, idx} == (len - LEN_ONE));
        start_any  = (state == BK_IDLE) && (len != '0) && (bk_load || bk_save);
        start_save = start_any && !bk_load;
        if (state == BK_IDLE) begin
            b_addr = '0;
        end else if (state == BK_SAVE_XFER && sv_out_ready) begin
            b_addr = idx + 1'b1;
        end
        b_we      = (state == BK_LOAD) && sv_in_valid;
        dirty_set = ram_wr && (len != '0);
        dirty_clr = start_save || (b_we && last);
    end

    cart_dpram #(.ADDR_W(ADDR_W)) u_dpram (
        .clk_sys (clk_sys),
        .reset   (reset),
        .a_addr  (ram_addr),
        .a_we    (ram_wr),
        .a_di    (ram_di),
        .a_do    (ram_do),
        .b_addr  (b_addr),
        .b_we    (b_we),
        .b_di    (sv_in_data),
        .b_do    (b_do)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= BK_IDLE;
            idx          <= '0;
            bk_busy      <= 1'b0;
            bk_done      <= 1'b0;
            bk_dirty     <= 1'b0;
            sv_out_data  <= 8'h00;
            sv_out_valid <= 1'b0;
            sv_in_ready  <= 1'b0;
        end else begin
            bk_done <= 1'b0;
            if (dirty_set) begin
                bk_dirty <= 1'b1;
            end else if (dirty_clr) begin
                bk_dirty <= 1'b0;
            end
            case (state)
                BK_IDLE: begin
                    if (start_any) begin
                        idx     <= '0;
                        bk_busy <= 1'b1;
                        if (bk_load) begin
                            state       <= BK_LOAD;
                            sv_in_ready <= 1'b1;
                        end else begin
                            state <= BK_SAVE_RD;
                        end
                    end
                end
                BK_SAVE_RD: begin
                    sv_out_data  <= b_do;
                    sv_out_valid <= 1'b1;
                    state        <= BK_SAVE_XFER;
                end
                BK_SAVE_XFER: begin
                    if (sv_out_ready) begin
                        sv_out_valid <= 1'b0;
                        idx          <= idx + 1'b1;
                        state        <= last ? BK_DONE : BK_SAVE_RD;
                    end
                end
                BK_LOAD: begin
                    if (sv_in_valid) begin
                        idx <= idx + 1'b1;
                        if (last) begin
                            sv_in_ready <= 1'b0;
                            state       <= BK_DONE;
                        end
                    end
                end
                BK_DONE: begin
                    bk_done <= 1'b1;
                    bk_busy <= 1'b0;
                    state   <= BK_IDLE;
                end
                default: state <= BK_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cart_ram_store.sv
// tb/tb_cart_ram_store.sv - scoreboard bench for cart_ram_store
module tb_cart_ram_store;

    logic        clk_sys;
    logic        reset;
    logic [16:0] ram_addr;
    logic        ram_rd;
    logic        ram_wr;
    logic [7:0]  ram_di;
    logic [7:0]  ram_do;
    logic [7:0]  cart_mbc_type;
    logic [7:0]  cart_ram_size;
    logic        bk_load;
    logic        bk_save;
    logic        bk_busy;
    logic        bk_done;
    logic        bk_dirty;
    logic [7:0]  sv_out_data;
    logic        sv_out_valid;
    logic        sv_out_ready;
    logic [7:0]  sv_in_data;
    logic        sv_in_valid;
    logic        sv_in_ready;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  model [0:2047];

    cart_ram_store dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ram_addr      (ram_addr),
        .ram_rd        (ram_rd),
        .ram_wr        (ram_wr),
        .ram_di        (ram_di),
        .ram_do        (ram_do),
        .cart_mbc_type (cart_mbc_type),
        .cart_ram_size (cart_ram_size),
        .bk_load       (bk_load),
        .bk_save       (bk_save),
        .bk_busy       (bk_busy),
        .bk_done       (bk_done),
        .bk_dirty      (bk_dirty),
        .sv_out_data   (sv_out_data),
        .sv_out_valid  (sv_out_valid),
        .sv_out_ready  (sv_out_ready),
        .sv_in_data    (sv_in_data),
        .sv_in_valid   (sv_in_valid),
        .sv_in_ready   (sv_in_ready)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required normal end");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic cpu_write(input logic [16:0] addr, input logic [7:0] data);
        ram_addr = addr;
        ram_di   = data;
        ram_wr   = 1'b1;
        step();
        ram_wr   = 1'b0;
        if (addr < 17'd2048) model[addr[10:0]] = data;
    endtask

    task automatic cpu_read_check(input string tag, input logic [16:0] addr, input logic [7:0] exp);
        ram_addr = addr;
        ram_rd   = 1'b1;
        exp_q.push_back(exp);
        step();
        ram_rd   = 1'b0;
        check(tag, 32'(ram_do), 32'(exp_q.pop_front()));
    endtask

    function automatic logic [7:0] load_pat(input int pat, input int i);
        return (pat == 0) ? 8'(i) : (8'(i) ^ 8'h5A);
    endfunction

    // Runs a SAVE of len bytes; stops early after abort_at handshakes when abort_at >= 0.
    task automatic run_save(input int len, input bit rnd, input int abort_at);
        int         got;
        int         dones;
        bit         stalled;
        logic [7:0] held;
        got     = 0;
        dones   = 0;
        stalled = 0;
        held    = 8'h00;
        exp_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(model[i]);
        bk_save = 1'b1;
        step();
        bk_save = 1'b0;
        check("save_busy", 32'(bk_busy), 1);
        for (int cyc = 0; cyc < 6 * len + 50; cyc++) begin
            if (abort_at >= 0 && got == abort_at) break;
            sv_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                check("save_hold_valid", 32'(sv_out_valid), 1);
                check("save_hold_data", 32'(sv_out_data), 32'(held));
            end
            if (sv_out_valid && sv_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("save_extra_byte", 32'(got), 32'(len));
                end else begin
                    check("save_data", 32'(sv_out_data), 32'(exp_q.pop_front()));
                end
                got++;
                stalled = 0;
            end else if (sv_out_valid) begin
                stalled = 1;
                held    = sv_out_data;
            end else begin
                stalled = 0;
            end
            step();
            if (bk_done) dones++;
            if (dones > 0) break;
        end
        sv_out_ready = 1'b0;
        if (abort_at < 0) begin
            for (int k = 0; k < 4; k++) begin
                step();
                if (bk_done) dones++;
            end
            check("save_count", 32'(got), 32'(len));
            check("save_done_once", 32'(dones), 1);
            check("save_dirty_clr", 32'(bk_dirty), 0);
            check("save_busy_clr", 32'(bk_busy), 0);
        end else begin
            check("save_abort_point", 32'(got), 32'(abort_at));
            check("save_abort_nodone", 32'(dones), 0);
        end
    endtask

    task automatic run_load(input int len, input bit rnd, input int pat, input bit both);
        int i;
        int dones;
        bit out_seen;
        i        = 0;
        dones    = 0;
        out_seen = 0;
        bk_load  = 1'b1;
        bk_save  = both;
        step();
        bk_load  = 1'b0;
        bk_save  = 1'b0;
        check("load_ready_up", 32'(sv_in_ready), 1);
        check("load_no_out_valid", 32'(sv_out_valid), 0);
        if (both) begin
            bk_save = 1'b1;
            step();
            bk_save = 1'b0;
        end
        for (int cyc = 0; cyc < 8 * len + 50; cyc++) begin
            if (i < len) begin
                sv_in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                sv_in_data  = load_pat(pat, i);
            end else begin
                sv_in_valid = 1'b0;
            end
            if (sv_in_valid && sv_in_ready) begin
                model[i] = sv_in_data;
                i++;
            end
            if (sv_out_valid) out_seen = 1;
            step();
            if (bk_done) dones++;
            if (dones > 0) break;
        end
        sv_in_valid = 1'b1;
        sv_in_data  = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            check("load_extra_ready", 32'(sv_in_ready), 0);
            if (sv_out_valid) out_seen = 1;
            step();
            if (bk_done) dones++;
        end
        sv_in_valid = 1'b0;
        check("load_count", 32'(i), 32'(len));
        check("load_done_once", 32'(dones), 1);
        check("load_out_silent", 32'(out_seen), 0);
        check("load_busy_clr", 32'(bk_busy), 0);
    endtask

    initial begin
        int busy_seen;
        int done_seen;
        reset         = 1'b1;
        ram_addr      = '0;
        ram_rd        = 1'b0;
        ram_wr        = 1'b0;
        ram_di        = 8'h00;
        cart_mbc_type = 8'h01;
        cart_ram_size = 8'h02;
        bk_load       = 1'b0;
        bk_save       = 1'b0;
        sv_out_ready  = 1'b0;
        sv_in_data    = 8'h00;
        sv_in_valid   = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check("rst_ram_do", 32'(ram_do), 0);
        check("rst_busy", 32'(bk_busy), 0);
        check("rst_done", 32'(bk_done), 0);
        check("rst_dirty", 32'(bk_dirty), 0);
        check("rst_out_valid", 32'(sv_out_valid), 0);
        check("rst_out_data", 32'(sv_out_data), 0);
        check("rst_in_ready", 32'(sv_in_ready), 0);
        reset = 1'b0;
        step();

        // CPU write/read, read-during-write returns old data
        cpu_write(17'h0123, 8'hA5);
        cpu_read_check("cpu_read_a5", 17'h0123, 8'hA5);
        check("cpu_dirty_set", 32'(bk_dirty), 1);
        cpu_write(17'h0123, 8'h3C);
        check("cpu_rdw_old", 32'(ram_do), 32'hA5);
        cpu_read_check("cpu_read_3c", 17'h0123, 8'h3C);

        // SAVE 2048 bytes with random backpressure
        cart_ram_size = 8'h01;
        for (int a = 0; a < 2048; a++) cpu_write(17'(a), 8'(a * 7 + 3));
        check("fill_dirty", 32'(bk_dirty), 1);
        run_save(2048, 1'b1, -1);

        // LOAD 512 bytes on MBC2 with valid gaps
        cart_mbc_type = 8'h05;
        cart_ram_size = 8'h00;
        cpu_write(17'h0100, 8'h99);
        check("mbc2_dirty", 32'(bk_dirty), 1);
        run_load(512, 1'b1, 0, 1'b0);
        check("load_dirty_clr", 32'(bk_dirty), 0);
        for (int a = 0; a < 512; a++) cpu_read_check("load_readback", 17'(a), model[a]);
        cpu_read_check("load_513th_untouched", 17'h0200, model[512]);

        // LEN = 0: start ignored, writes do not mark dirty
        cart_mbc_type = 8'h01;
        cart_ram_size = 8'h00;
        cpu_write(17'h0010, 8'h77);
        check("len0_no_dirty", 32'(bk_dirty), 0);
        busy_seen = 0;
        done_seen = 0;
        bk_save   = 1'b1;
        step();
        bk_save   = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bk_busy) busy_seen = 1;
            if (bk_done) done_seen = 1;
            step();
        end
        check("len0_no_busy", 32'(busy_seen), 0);
        check("len0_no_done", 32'(done_seen), 0);

        // load+save together: LOAD wins, later save while busy ignored
        cart_ram_size = 8'h01;
        run_load(2048, 1'b0, 1, 1'b1);
        check("post_load_idle_valid", 32'(sv_out_valid), 0);

        // Reset mid-SAVE, then full re-SAVE from byte 0
        run_save(2048, 1'b0, 100);
        reset = 1'b1;
        step();
        check("rst_mid_busy", 32'(bk_busy), 0);
        check("rst_mid_valid", 32'(sv_out_valid), 0);
        reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (bk_done) done_seen = 1;
            step();
        end
        check("rst_mid_nodone", 32'(done_seen), 0);
        run_save(2048, 1'b1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
